// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM encoding, frame width
// and the default byte returned when nothing is queued for transmit.
package spi_pkg;

    localparam int FRAME_W = 8;

    typedef logic [FRAME_W-1:0] byte_t;

    localparam byte_t IDLE_BYTE_DEFAULT = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin followed by a rise/fall
// detector; pulses are valid for one clk cycle after the synchronized level moves.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;
    logic              sync_s;

    always_comb begin
        chain_d    = chain_q << 1;
        chain_d[0] = d;
        prev_d     = chain_q[STAGES-1];
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_s = chain_q[STAGES-1];
    assign rise   = sync_s & ~prev_q;
    assign fall   = ~sync_s & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled by clk. A one-entry
// holding register feeds the transmit shifter; IDLE_BYTE fills in when it is empty.
module spi_slave
    import spi_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter byte_t IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         spi_sclk,
    input  logic         spi_cs_n,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic         spi_miso_oe,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [7:0]   rx_data,
    output logic         rx_valid,
    output logic         tx_underrun,
    output logic         busy
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_cs_n),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    // MOSI needs only the level; its timing matches the sclk synchronizer.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    always_comb begin
        mosi_sync_d    = mosi_sync_q << 1;
        mosi_sync_d[0] = spi_mosi;
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    byte_t      rx_shift_q, rx_shift_d;
    byte_t      tx_shift_q, tx_shift_d;
    byte_t      hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    byte_t      rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_underrun_q, tx_underrun_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; deselect wins over everything else.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state_q == ST_SHIFT);
        spi_miso_oe = busy;
        spi_miso    = busy ? tx_shift_q[FRAME_W-1] : 1'b0;
    end

    logic  in_shift, rise_act, fall_act, load, accept;
    byte_t load_byte;

    assign in_shift  = (state_q == ST_SHIFT) && !cs_rise;
    assign rise_act  = in_shift && sclk_rise;
    assign fall_act  = in_shift && sclk_fall;
    assign load      = ((state_q == ST_IDLE) && cs_fall) || (fall_act && (bit_cnt_q == 3'd0));
    assign load_byte = hold_full_q ? hold_q : IDLE_BYTE;
    assign accept    = tx_valid && !hold_full_q;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;

        if (cs_rise || ((state_q == ST_IDLE) && cs_fall)) bit_cnt_d = 3'd0;

        if (rise_act) begin
            rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_data_d  = {rx_shift_q[FRAME_W-2:0], mosi_s};
                rx_valid_d = 1'b1;
            end
        end

        if (fall_act && (bit_cnt_q != 3'd0)) tx_shift_d = tx_shift_q << 1;

        // An accept in the same cycle as a load lands after the load has read the register.
        if (load) begin
            tx_shift_d    = load_byte;
            tx_underrun_d = !hold_full_q;
            hold_full_d   = 1'b0;
        end

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_sync_q   <= '0;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master plus a load-level model of the
// holding register, with per-cycle checks of select, receive and underrun behaviour.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int         SYNC = 2;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    spi_slave #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #21 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: holding register contents, expected byte streams and pulse counts.
    bit         model_full = 1'b0;
    logic [7:0] model_hold = 8'h00;
    int         ur_exp = 0, ur_seen = 0, rx_seen = 0;
    logic [7:0] exp_rx[$], exp_miso[$], mosi_q[$], offer_q[$], miso_got[$];

    logic [SYNC:0] cs_pipe = '1;
    logic          last_rxv = 1'b0, last_ur = 1'b0;
    logic [7:0]    last_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every load takes the held byte if present, otherwise the idle byte with an underrun.
    task automatic model_load();
        if (model_full) begin
            exp_miso.push_back(model_hold);
            model_full = 1'b0;
        end else begin
            exp_miso.push_back(IDLE);
            ur_exp++;
        end
    endtask

    // Chip select as seen by the slave after the synchronizer plus edge-detect latency.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cs_pipe = '1;
        else          cs_pipe = {cs_pipe[SYNC-1:0], spi_cs_n};
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("oe", spi_miso_oe, !cs_pipe[SYNC]);
            check("busy", busy, !cs_pipe[SYNC]);
            if (cs_pipe[SYNC]) check("miso_idle", spi_miso, 1'b0);
            if (rx_valid) begin
                rx_seen++;
                check("rx_valid_width", last_rxv, 1'b0);
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
                else                    check("rx_data", rx_data, exp_rx.pop_front());
            end else begin
                check("rx_data_hold", rx_data, last_rx);
            end
            if (tx_underrun) begin
                ur_seen++;
                check("underrun_width", last_ur, 1'b0);
            end
            last_rxv = rx_valid;
            last_ur  = tx_underrun;
            last_rx  = rx_data;
        end else begin
            last_rxv = 1'b0;
            last_ur  = 1'b0;
            last_rx  = 8'h00;
        end
    end

    task automatic preload(input logic [7:0] v);
        @(negedge clk);
        check("tx_ready_idle", tx_ready, !model_full);
        if (!model_full) begin
            tx_data    = v;
            tx_valid   = 1'b1;
            model_hold = v;
            model_full = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        @(negedge clk);
        check("tx_ready_held", tx_ready, !model_full);
    endtask

    // One chip-select assertion: nbytes full bytes then tail extra bits, half period h clks.
    // vmode 1 offers cb exactly at the select load; vmode 2 holds cb valid from select on.
    task automatic frame(input int nbytes, input int tail, input int h,
                         input int vmode, input logic [7:0] cb);
        int vs, ve, nb;
        logic [7:0] mb, got, mask, expb;
        bit last;
        vs = (vmode == 1) ? SYNC     : ((vmode == 2) ? 0        : -1);
        ve = (vmode == 1) ? SYNC + 1 : ((vmode == 2) ? SYNC + 2 : -1);
        miso_got.delete();
        @(negedge clk);
        spi_cs_n = 1'b0;
        model_load();
        for (int k = 0; k < SYNC + 4; k++) begin
            if (k == vs) begin tx_data = cb; tx_valid = 1'b1; end
            if (k == ve) tx_valid = 1'b0;
            @(negedge clk);
        end
        if (vmode != 0) begin model_full = 1'b1; model_hold = cb; end
        for (int b = 0; b <= nbytes; b++) begin
            nb = (b < nbytes) ? 8 : tail;
            if (nb == 0) break;
            mb = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'($urandom);
            if (nb == 8) exp_rx.push_back(mb);
            got  = 8'h00;
            last = 1'b0;
            for (int i = 0; i < nb; i++) begin
                last = (b == nbytes - 1 && i == 7 && tail == 0) || (b == nbytes && i == tail - 1);
                spi_mosi = mb[7-i];
                repeat (h) @(negedge clk);
                got[7-i] = spi_miso;
                spi_sclk = 1'b1;
                if (i == 2) begin
                    check("tx_ready", tx_ready, !model_full);
                    if (offer_q.size() > 0 && !model_full) begin
                        tx_data    = offer_q.pop_front();
                        tx_valid   = 1'b1;
                        model_hold = tx_data;
                        model_full = 1'b1;
                        @(negedge clk);
                        tx_valid = 1'b0;
                    end
                end
                repeat (h) @(negedge clk);
                spi_sclk = 1'b0;
                if (last) spi_cs_n = 1'b1;
            end
            mask = 8'hFF << (8 - nb);
            expb = exp_miso.pop_front();
            check("miso_byte", got & mask, expb & mask);
            miso_got.push_back(got);
            if (nb == 8 && !last) model_load();
        end
        repeat (SYNC + 4) @(negedge clk);
        check("oe_after_deselect", spi_miso_oe, 1'b0);
        check("underrun_count", ur_seen, ur_exp);
        check("rx_outstanding", exp_rx.size(), 0);
    endtask

    // Reset asserted in the middle of the fourth bit while a byte is held.
    task automatic reset_mid();
        @(negedge clk);
        spi_cs_n = 1'b0;
        model_load();
        repeat (SYNC + 4) @(negedge clk);
        tx_data = 8'h88; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_underrun", tx_underrun, 1'b0);
        spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        model_full = 1'b0;
        exp_miso.delete();
        exp_rx.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ur0, rx0, nbytes, tail;
        #5;
        check("init_oe", spi_miso_oe, 1'b0);
        check("init_miso", spi_miso, 1'b0);
        check("init_busy", busy, 1'b0);
        check("init_tx_ready", tx_ready, 1'b1);
        check("init_rx_data", rx_data, 8'h00);
        check("init_rx_valid", rx_valid, 1'b0);
        check("init_underrun", tx_underrun, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Preloaded byte goes out while a byte comes in.
        ur0 = ur_seen; rx0 = rx_seen;
        preload(8'hA5);
        mosi_q.push_back(8'h3C);
        frame(1, 0, 4, 0, 8'h00);
        check("d1_miso", miso_got[0], 8'hA5);
        check("d1_rx_data", rx_data, 8'h3C);
        check("d1_underruns", ur_seen - ur0, 0);
        check("d1_rx_pulses", rx_seen - rx0, 1);

        // Empty holding register: idle bytes and one underrun per load.
        ur0 = ur_seen; rx0 = rx_seen;
        frame(2, 0, 4, 0, 8'h00);
        check("d2_miso0", miso_got[0], 8'hFF);
        check("d2_miso1", miso_got[1], 8'hFF);
        check("d2_underruns", ur_seen - ur0, 2);
        check("d2_rx_pulses", rx_seen - rx0, 2);

        // Second byte accepted right after the first load.
        ur0 = ur_seen;
        preload(8'h11);
        frame(2, 0, 5, 2, 8'h22);
        check("d3_miso0", miso_got[0], 8'h11);
        check("d3_miso1", miso_got[1], 8'h22);
        check("d3_underruns", ur_seen - ur0, 0);
        check("d3_tx_ready_after", tx_ready, 1'b1);

        // Accept in the same cycle as the select load from an empty register.
        ur0 = ur_seen;
        frame(2, 0, 4, 1, 8'h5A);
        check("d4_miso0", miso_got[0], 8'hFF);
        check("d4_miso1", miso_got[1], 8'h5A);
        check("d4_underruns", ur_seen - ur0, 1);

        // Abort after five bits, then a clean byte.
        rx0 = rx_seen;
        mosi_q.push_back(8'hE7);
        frame(0, 5, 4, 0, 8'h00);
        check("d5_no_rx", rx_seen - rx0, 0);
        mosi_q.push_back(8'h96);
        frame(1, 0, 4, 0, 8'h00);
        check("d5_rx_data", rx_data, 8'h96);

        // SCLK activity while deselected.
        rx0 = rx_seen;
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("d6_no_rx", rx_seen - rx0, 0);
        check("d6_oe", spi_miso_oe, 1'b0);

        // Reset mid-byte, then a transfer after release.
        reset_mid();
        repeat (2) @(negedge clk);
        mosi_q.push_back(8'hC3);
        frame(1, 0, 4, 0, 8'h00);
        check("d7_miso", miso_got[0], 8'hFF);
        check("d7_rx_data", rx_data, 8'hC3);

        // Randomized frames, offers and preloads.
        for (int f = 0; f < 10; f++) begin
            nbytes = $urandom_range(1, 3);
            tail   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            repeat ($urandom_range(0, 2)) offer_q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) preload(8'($urandom));
            frame(nbytes, tail, $urandom_range(4, 6), 0, 8'h00);
            offer_q.delete();
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flop stages that synchronize spi_sclk, spi_mosi and spi_cs_n into clk.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, byte shifted out when no transmit data is held.
REQ-003 SHALL have port clk  input  1  system clock (24 MHz nominal), the only clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock from the external master.
REQ-006 SHALL have port spi_cs_n  input  1  chip select, active-low.
REQ-007 SHALL have port spi_mosi  input  1  serial data from the master.
REQ-008 SHALL have port spi_miso  output  1  serial data to the master.
REQ-009 SHALL have port spi_miso_oe  output  1  MISO pad output enable, high while selected.
REQ-010 SHALL have port tx_data  input  8  next byte to transmit.
REQ-011 SHALL have port tx_valid  input  1  tx_data valid.
REQ-012 SHALL have port tx_ready  output  1  holding register empty; transfer occurs on tx_valid&&tx_ready.
REQ-013 SHALL have port rx_data  output  8  last complete received byte.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-015 SHALL have port tx_underrun  output  1  one-cycle pulse, IDLE_BYTE was loaded because holding was empty.
REQ-016 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-017 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, back-to-back bytes within one chip-select assertion.
REQ-018 SHALL operate only on synchronized inputs; edges are detected one cycle after the synchronizer output, which gives a total detect latency of SYNC_STAGES+1 clk cycles.
REQ-019 SHALL support spi_sclk up to clk/8, i.e. each SCLK half-period lasts at least 4 clk cycles.
REQ-020 SHALL have FSM states IDLE and SHIFT.
REQ-021 IDLE->SHIFT on a detected cs_n falling edge: load the shifter from the holding register, or from IDLE_BYTE if it is empty; clear the bit count to 0; drive spi_miso = shifter[7]; set spi_miso_oe = 1.
REQ-022 In SHIFT, on each detected sclk rising edge: shift the synchronized mosi into the receive shifter LSB and increment the 3-bit bit count.
REQ-023 In SHIFT, on each detected sclk falling edge with bit count != 0: shift the transmit shifter left and drive the new bit 7 onto spi_miso.
REQ-024 On the rising edge that completes bit 8 (bit count wraps 7->0): rx_data <= the assembled byte; rx_valid pulses for exactly 1 cycle, in the cycle after that edge is detected.
REQ-025 On the falling edge following a wrap to 0: reload the transmit shifter from the holding register or from IDLE_BYTE, and drive the new bit 7.
REQ-026 SHALL pulse tx_underrun for 1 cycle on every load of IDLE_BYTE, including the load at select.
REQ-027 Holding register is one entry: tx_ready = holding empty; tx_ready SHALL be 1 while idle and empty.
REQ-028 On a simultaneous load and accept in the same cycle while the register is empty, the load SHALL use IDLE_BYTE and the accepted byte SHALL remain held for the next load.
REQ-029 A load empties the holding register; tx_ready SHALL rise the next cycle.
REQ-030 A detected cs_n rising edge in any state SHALL cause a return to IDLE: spi_miso_oe = 0, partial receive bits discarded, no rx_valid pulse, partial transmit byte lost, holding register untouched.
REQ-031 SCLK edges while in IDLE SHALL be ignored.
REQ-032 rx_valid SHALL have no backpressure; a new byte overwrites rx_data.

Reset
REQ-033 While reset_n = 0: state = IDLE; synchronizers = idle levels (sclk 0, cs_n 1, mosi 0); spi_miso = 0; spi_miso_oe = 0; busy = 0; tx_ready = 1 (holding empty); rx_data = 8'h00; rx_valid = 0; tx_underrun = 0; bit count = 0.
REQ-034 Asserting reset mid-transfer SHALL abort the transfer immediately; after release the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-035 Package spi_pkg SHALL hold the FSM state encoding (IDLE, SHIFT), the frame width constant 8, and the default IDLE_BYTE.
REQ-036 Sub-module spi_sync_edge SHALL hold the SYNC_STAGES synchronizer plus the rise/fall pulse detector, instantiated for sclk and cs_n; mosi uses its synchronizer stage only.

Verification
REQ-037 Preload 8'hA5, assert cs_n, clock 8 bits of 8'h3C at clk/8 -> MISO shows A5 MSB-first; rx_data = 8'h3C with one rx_valid pulse; no tx_underrun.
REQ-038 Select with the holding register empty, 2 bytes -> MISO shows FF FF; tx_underrun pulses twice; rx_valid pulses twice.
REQ-039 Preload 8'h11, accept 8'h22 at the first byte's load, then transfer 2 bytes back-to-back -> MISO shows 11 then 22; tx_ready is 0 until the second load.
REQ-040 Deassert cs_n after 5 bits -> no rx_valid; spi_miso_oe = 0 within SYNC_STAGES+2 cycles; the next transfer receives 8'h96 correctly.
REQ-041 Assert reset_n = 0 mid-byte -> all outputs take their REQ-033 values asynchronously; a transfer after release works.
REQ-042 Toggle SCLK with cs_n high -> no rx_valid and MISO remains disabled.
